comm_link_framer: RTL and testbench
===================================

COMM_LINK_FRAMER -- requirements
Module: comm_link_framer

Interface
REQ-001 Parameter DATA_W, default 8, payload word width; legal range 4..32.
REQ-002 Parameter OUT_W, default 16, data_out width; legal only if OUT_W >= DATA_W and OUT_W >= 6.
REQ-003 Parameter PREAMBLE, default 8'hA5, 8-bit frame sync pattern; legal only if nonzero.
REQ-004 Parameter PARITY_EN, default 1; 1 appends an even-parity bit, 0 omits it.
REQ-005 sysclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  DATA_W  payload word offered for transmission.
REQ-008 in_valid  input  1  data_in is valid.
REQ-009 in_ready  output  1  framer accepts a word this cycle.
REQ-010 err_inject  input  1  sampled at accept; inverts the parity bit of that frame.
REQ-011 out_select  input  2  selects the data_out source.
REQ-012 data_out  output  OUT_W  selected observation word.
REQ-013 ser_out  output  1  registered serial line, internally looped to the receiver.
REQ-014 rx_valid  output  1  one-cycle pulse when a received word is delivered.

Function
REQ-015 Frame length L = 8 + DATA_W + PARITY_EN bits, one bit per sysclk cycle, all fields MSB first: PREAMBLE, then payload, then parity.
REQ-016 TX FSM: IDLE(0) -> PRE(1) after accept; PRE -> DATA(2) after 8 bits; DATA -> PAR(3) after DATA_W bits when PARITY_EN=1, else -> IDLE; PAR -> IDLE after 1 bit.
REQ-017 in_ready SHALL equal (tx_state==IDLE) & ~reset; a word is accepted on an edge with in_valid & in_ready, and data_in and err_inject are captured at that edge.
REQ-018 in_valid while busy SHALL be ignored with no effect on the frame in flight.
REQ-019 With accept at edge k, ser_out SHALL carry frame bit i after edge k+i for i = 0..L-1 and return to 0 at edge k+L, where TX re-enters IDLE; frames are therefore separated by at least one idle 0 bit.
REQ-020 Parity bit = XOR of payload bits, XORed with the captured err_inject.
REQ-021 RX FSM: HUNT(0), DATA(1), PAR(2); RX samples ser_out every edge.
REQ-022 In HUNT, an 8-bit shift register SHALL be compared with PREAMBLE after each shift; on match RX enters DATA.
REQ-023 The shift register SHALL be cleared on reset and on every re-entry to HUNT.
REQ-024 After DATA_W payload samples, RX SHALL go to PAR when PARITY_EN=1, else deliver and return to HUNT; PAR SHALL sample one bit, then deliver and return to HUNT.
REQ-025 Deliver: rx_word <= payload and rx_valid = 1 for exactly one cycle, at edge k+L (latency L from accept edge; 17 at defaults).
REQ-026 A parity mismatch SHALL increment err_count (OUT_W bits, saturating at all-ones) and SHALL still deliver the word.
REQ-027 With PARITY_EN=0, err_count SHALL remain 0 and err_inject SHALL be ignored.
REQ-028 data_out selection, all sources zero-extended:
  00 last accepted tx word
  01 status word {tx_state[5:4], rx_state[3:2], ser_out[1], in_ready[0]}
  10 rx_word
  11 err_count
REQ-029 data_out SHALL be combinational from registered state and out_select; changing out_select SHALL take effect in the same cycle.

Reset
REQ-030 While reset is high at an edge: tx_state=IDLE, rx_state=HUNT, and ser_out, rx_valid, rx_word, err_count, last tx word and shift register all cleared to 0; in_ready=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; no rx_valid for it and no err_count change; the first edge with reset low behaves as idle.

Verification
REQ-032 Defaults, accept 8'h69 at edge k -> ser_out = 10100101 01101001 0, then 0; rx_valid at k+17; out_select=10 gives 16'h0069; err_count 0.
REQ-033 Accept 8'hEF with err_inject=1 -> parity bit 0 (nominal 1); rx_valid at k+17; rx_word 16'h00EF; out_select=11 gives 16'h0001.
REQ-034 in_valid held high with 8'h69 then 8'hEF -> accepts at k and k+18; the second word is not accepted during cycles k+1..k+17; two rx_valid pulses.
REQ-035 Reset asserted at k+8, released at k+10 -> no rx_valid; all outputs zero; the next frame then decodes correctly.
REQ-036 PARITY_EN=0, DATA_W=12, accept 12'hABC -> L=20; rx_valid at k+20; rx_word 16'h0ABC; err_count stays 0 even with err_inject=1.
REQ-037 out_select=01 during the PRE phase -> data_out[5:4]=1, [3:2]=0, [0]=0; after delivery -> 6'b000001 (ser_out 0, in_ready 1).

Source files
------------

// File: rtl/comm_link_framer.sv
// comm_link_framer: preamble/payload/parity serial framer whose line is looped back into
// a preamble-hunting receiver that delivers words and counts parity errors.
module comm_link_framer #(
   parameter int         DATA_W    = 8,
   parameter int         OUT_W     = 16,
   parameter logic [7:0] PREAMBLE  = 8'hA5,
   parameter bit         PARITY_EN = 1'b1
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              err_inject,
   input  logic [1:0]        out_select,
   output logic [OUT_W-1:0]  data_out,
   output logic              ser_out,
   output logic              rx_valid
);
   localparam int L  = 8 + DATA_W + (PARITY_EN ? 1 : 0);
   localparam int IW = $clog2(L + 1);
   localparam int CW = $clog2(DATA_W);
   localparam logic [IW-1:0] C_PRE_END  = IW'(8);
   localparam logic [IW-1:0] C_DAT_END  = IW'(8 + DATA_W);
   localparam logic [IW-1:0] C_LEN      = IW'(L);
   localparam logic [CW-1:0] C_DAT_LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_PRE = 2'd1, TX_DATA = 2'd2, TX_PAR = 2'd3} tx_state_t;
   typedef enum logic [1:0] {RX_HUNT = 2'd0, RX_DATA = 2'd1, RX_PAR = 2'd2} rx_state_t;

   tx_state_t         r_tx_state, w_tx_next;
   rx_state_t         r_rx_state, w_rx_next;
   logic [IW-1:0]     r_tx_idx, w_tx_idx_inc;
   logic [L-2:0]      r_tx_sh;
   logic [7+DATA_W:0] w_tx_load;
   logic [DATA_W-1:0] r_tx_word;
   logic              r_ser, w_accept, w_tx_par;
   logic [7:0]        r_rx_sh, w_rx_sh_shift;
   logic [DATA_W-1:0] r_rx_data, w_rx_data_shift, r_rx_word, w_rx_word;
   logic [CW-1:0]     r_rx_cnt;
   logic              w_rx_last, w_deliver, w_par_err, r_rx_valid;
   logic [OUT_W-1:0]  r_err_cnt;
   logic [5:0]        w_status;

   assign w_accept     = in_valid & in_ready;
   assign w_tx_idx_inc = r_tx_idx + 1'b1;
   assign w_tx_par     = PARITY_EN & (^data_in ^ err_inject);
   assign w_tx_load    = {PREAMBLE[6:0], data_in, w_tx_par};

   always_ff @(posedge sysclk)
      if (reset) r_tx_state <= TX_IDLE;
      else r_tx_state <= w_tx_next;

   // r_tx_idx is the index of the frame bit currently on the line
   always_comb begin
      w_tx_next = r_tx_state;
      if (r_tx_state == TX_IDLE)
         w_tx_next = w_accept ? TX_PRE : TX_IDLE;
      else
         w_tx_next = (w_tx_idx_inc < C_PRE_END) ? TX_PRE :
                     (w_tx_idx_inc < C_DAT_END) ? TX_DATA :
                     (w_tx_idx_inc < C_LEN)     ? TX_PAR : TX_IDLE;
   end

   always_comb in_ready = (r_tx_state == TX_IDLE) & ~reset;

   // The shifter drains to zero by the end of the frame, so the idle line is 0
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_tx_idx  <= '0;
         r_tx_sh   <= '0;
         r_tx_word <= '0;
         r_ser     <= 1'b0;
      end else if (w_accept) begin
         r_tx_idx  <= '0;
         r_tx_sh   <= w_tx_load[7+DATA_W -: L-1];
         r_tx_word <= data_in;
         r_ser     <= PREAMBLE[7];
      end else begin
         r_tx_idx  <= (r_tx_state == TX_IDLE) ? '0 : w_tx_idx_inc;
         r_tx_sh   <= r_tx_sh << 1;
         r_ser     <= r_tx_sh[L-2];
      end
   end

   assign w_rx_sh_shift   = {r_rx_sh[6:0], r_ser};
   assign w_rx_data_shift = {r_rx_data[DATA_W-2:0], r_ser};
   assign w_rx_last       = (r_rx_cnt == C_DAT_LAST);

   always_ff @(posedge sysclk)
      if (reset) r_rx_state <= RX_HUNT;
      else r_rx_state <= w_rx_next;

   always_comb begin
      w_rx_next = RX_HUNT;
      if (r_rx_state == RX_HUNT)
         w_rx_next = (w_rx_sh_shift == PREAMBLE) ? RX_DATA : RX_HUNT;
      else if (r_rx_state == RX_DATA)
         w_rx_next = !w_rx_last ? RX_DATA : PARITY_EN ? RX_PAR : RX_HUNT;
   end

   always_comb begin
      w_deliver = (r_rx_state == RX_PAR) | ((r_rx_state == RX_DATA) & w_rx_last & ~PARITY_EN);
      w_rx_word = (r_rx_state == RX_PAR) ? r_rx_data : w_rx_data_shift;
      w_par_err = (r_rx_state == RX_PAR) & (r_ser ^ (^r_rx_data));
   end

   // Hunt register only accumulates while hunting, so it is zero on every re-entry
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_rx_sh    <= '0;
         r_rx_data  <= '0;
         r_rx_cnt   <= '0;
         r_rx_valid <= 1'b0;
         r_rx_word  <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_rx_sh    <= (r_rx_state == RX_HUNT && w_rx_next == RX_HUNT) ? w_rx_sh_shift : '0;
         r_rx_data  <= (r_rx_state == RX_DATA) ? w_rx_data_shift : r_rx_data;
         r_rx_cnt   <= (r_rx_state == RX_DATA && !w_rx_last) ? r_rx_cnt + 1'b1 : '0;
         r_rx_valid <= w_deliver;
         if (w_deliver) r_rx_word <= w_rx_word;
         if (w_par_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign w_status = {r_tx_state, r_rx_state, r_ser, in_ready};
   assign ser_out  = r_ser;
   assign rx_valid = r_rx_valid;

   always_comb
      data_out = (out_select == 2'd0) ? OUT_W'(r_tx_word) :
                 (out_select == 2'd1) ? OUT_W'(w_status) :
                 (out_select == 2'd2) ? OUT_W'(r_rx_word) : r_err_cnt;
endmodule

// File: tb/tb_comm_link_framer.sv
// tb_comm_link_framer: table, hand-written corner sequences and random frames checked
// against a frame-level model of the serial line and receiver.
module tb_comm_link_framer;
   localparam int L  = 17;
   localparam int L2 = 20;
   localparam logic [7:0] PRE = 8'hA5;

   typedef struct {
      logic [7:0]  d;
      logic        e;
      logic        par;
      logic [15:0] cnt;
   } vec_t;

   logic        sysclk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  data_in = '0;
   logic        in_valid = 1'b0;
   logic        err_inject = 1'b0;
   logic [1:0]  out_select = '0;
   logic        in_ready, ser_out, rx_valid;
   logic [15:0] data_out;
   logic [11:0] d2_data = '0;
   logic        d2_valid = 1'b0;
   logic        d2_err = 1'b0;
   logic [1:0]  d2_sel = '0;
   logic        d2_ready, d2_ser, d2_rxv;
   logic [15:0] d2_out;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [7:0]  m_rx = '0;
   logic [15:0] m_err = '0;
   vec_t        tbl [7];
   logic [11:0] v2 [2];

   always #5 sysclk = ~sysclk;

   comm_link_framer dut (
      .sysclk(sysclk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready), .err_inject(err_inject), .out_select(out_select),
      .data_out(data_out), .ser_out(ser_out), .rx_valid(rx_valid)
   );

   comm_link_framer #(.DATA_W(12), .OUT_W(16), .PREAMBLE(8'hA5), .PARITY_EN(1'b0)) dut2 (
      .sysclk(sysclk), .reset(reset), .data_in(d2_data), .in_valid(d2_valid),
      .in_ready(d2_ready), .err_inject(d2_err), .out_select(d2_sel),
      .data_out(d2_out), .ser_out(d2_ser), .rx_valid(d2_rxv)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   // Frame bit i of a default-parameter frame: preamble, payload, parity, all MSB first
   function automatic logic fbit(input logic [7:0] d, input logic e, input int i);
      logic [16:0] f;
      logic [4:0]  k;
      f = {PRE, d, ^d ^ e};
      k = 5'(16 - i);
      return f[k];
   endfunction

   function automatic logic f2bit(input logic [11:0] v, input int i);
      logic [19:0] f;
      logic [4:0]  k;
      f = {PRE, v};
      k = 5'(19 - i);
      return f[k];
   endfunction

   function automatic logic [1:0] ptx(input int i);
      return (i < 8) ? 2'd1 : (i < 16) ? 2'd2 : 2'd3;
   endfunction

   function automatic logic [1:0] prx(input int i);
      return (i < 8) ? 2'd0 : (i < 16) ? 2'd1 : 2'd2;
   endfunction

   task automatic send(input logic [7:0] d, input logic e, output logic par);
      logic [15:0] st;
      logic [15:0] ex;
      data_in = d;
      err_inject = e;
      in_valid = 1'b1;
      tick();
      par = 1'b0;
      for (int i = 0; i < L; i++) begin
         st = {10'd0, ptx(i), prx(i), fbit(d, e, i), 1'b0};
         ex = (out_select == 2'd0) ? {8'd0, d} : (out_select == 2'd1) ? st :
              (out_select == 2'd2) ? {8'd0, m_rx} : m_err;
         chk("ser_out", 32'(ser_out), 32'(fbit(d, e, i)));
         chk("rx_valid_busy", 32'(rx_valid), 32'd0);
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         chk("data_out_busy", 32'(data_out), 32'(ex));
         par = ser_out;
         in_valid = 1'($urandom);
         data_in = 8'($urandom);
         err_inject = 1'($urandom);
         out_select = 2'($urandom);
         tick();
      end
      in_valid = 1'b0;
      m_rx = d;
      m_err = m_err + {15'd0, e};
      chk("ser_idle", 32'(ser_out), 32'd0);
      chk("rx_valid_pulse", 32'(rx_valid), 32'd1);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      for (int s = 0; s < 4; s++) begin
         out_select = 2'(s);
         #1;
         ex = (s == 0) ? {8'd0, d} : (s == 1) ? 16'h0001 : (s == 2) ? {8'd0, m_rx} : m_err;
         chk("data_out_done", 32'(data_out), 32'(ex));
      end
      tick();
      chk("rx_valid_drop", 32'(rx_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic par;
      int   pulses;
      tbl[0] = '{8'h69, 1'b0, 1'b0, 16'd0};
      tbl[1] = '{8'hEF, 1'b1, 1'b0, 16'd1};
      tbl[2] = '{8'h00, 1'b0, 1'b0, 16'd1};
      tbl[3] = '{8'hFF, 1'b1, 1'b1, 16'd2};
      tbl[4] = '{8'hA5, 1'b0, 1'b0, 16'd2};
      tbl[5] = '{8'h01, 1'b0, 1'b1, 16'd2};
      tbl[6] = '{8'h80, 1'b1, 1'b0, 16'd3};
      v2[0] = 12'hABC;
      v2[1] = 12'h5A3;

      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_ser_out", 32'(ser_out), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      for (int s = 0; s < 4; s++) begin
         out_select = 2'(s);
         #1;
         chk("rst_data_out", 32'(data_out), 32'd0);
      end
      reset = 1'b0;
      out_select = 2'd1;
      #1;
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_status", 32'(data_out), 32'h0001);
      tick();

      for (int j = 0; j < 7; j++) begin
         send(tbl[j].d, tbl[j].e, par);
         chk("tbl_parity_bit", 32'(par), 32'(tbl[j].par));
         out_select = 2'd3;
         #1;
         chk("tbl_err_count", 32'(data_out), 32'(tbl[j].cnt));
      end

      // in_valid held: second word waits for the first frame to finish
      pulses = 0;
      out_select = 2'd0;
      data_in = 8'h69;
      err_inject = 1'b0;
      in_valid = 1'b1;
      tick();
      data_in = 8'hEF;
      for (int i = 1; i <= 36; i++) begin
         tick();
         pulses += int'(rx_valid);
         if (i <= 16) begin
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_tx_word", 32'(data_out), 32'h0069);
         end
         if (i == 17) begin
            chk("hold_rx_valid1", 32'(rx_valid), 32'd1);
            chk("hold_ready_back", 32'(in_ready), 32'd1);
         end
         if (i == 18) begin
            in_valid = 1'b0;
            chk("hold_second_word", 32'(data_out), 32'h00EF);
            chk("hold_second_start", 32'(ser_out), 32'd1);
            out_select = 2'd2;
         end
         if (i == 35) begin
            chk("hold_rx_valid2", 32'(rx_valid), 32'd1);
            chk("hold_rx_word2", 32'(data_out), 32'h00EF);
         end
      end
      chk("hold_pulses", 32'(pulses), 32'd2);
      m_rx = 8'hEF;

      // reset in the middle of a frame aborts it cleanly
      data_in = 8'h69;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 7; i++) tick();
      reset = 1'b1;
      tick();
      tick();
      chk("abort_ser_out", 32'(ser_out), 32'd0);
      chk("abort_rx_valid", 32'(rx_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      for (int s = 0; s < 4; s++) begin
         out_select = 2'(s);
         #1;
         chk("abort_data_out", 32'(data_out), 32'd0);
      end
      reset = 1'b0;
      m_rx = '0;
      m_err = '0;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         pulses += int'(rx_valid) + int'(ser_out);
      end
      chk("abort_quiet", 32'(pulses), 32'd0);
      chk("abort_err_count", 32'(data_out), 32'd0);
      send(8'hEF, 1'b0, par);
      chk("abort_next_par", 32'(par), 32'd1);

      for (int r = 0; r < 20; r++) begin
         logic [7:0] d;
         logic       e;
         int         gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
         d = 8'($urandom);
         e = ($urandom_range(0, 3) == 0);
         send(d, e, par);
      end

      // no-parity variant: 20-bit frame, err_inject has no effect
      for (int j = 0; j < 2; j++) begin
         chk("d2_ready", 32'(d2_ready), 32'd1);
         d2_data = v2[j];
         d2_err = 1'b1;
         d2_valid = 1'b1;
         tick();
         d2_valid = 1'b0;
         for (int i = 0; i < L2; i++) begin
            chk("d2_ser_out", 32'(d2_ser), 32'(f2bit(v2[j], i)));
            chk("d2_rx_busy", 32'(d2_rxv), 32'd0);
            tick();
         end
         chk("d2_rx_valid", 32'(d2_rxv), 32'd1);
         chk("d2_ser_idle", 32'(d2_ser), 32'd0);
         d2_sel = 2'd2;
         #1;
         chk("d2_rx_word", 32'(d2_out), 32'({4'd0, v2[j]}));
         d2_sel = 2'd3;
         #1;
         chk("d2_err_count", 32'(d2_out), 32'd0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
